// File: rtl/datapath_sequencer.sv
// datapath_sequencer: feeds operand beats to the 4-stage FP MAC datapath, sequences its stage enables and captures the result.
// Optional `ACC_RELU_EN: clamp negative results (including -0.0) to +0.0 at capture.
module datapath_sequencer #(
   parameter int MAX_BEATS_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [MAX_BEATS_W-1:0] num_beats,
   output logic                   busy,
   input  logic                   op_valid,
   output logic                   op_ready,
   input  logic [255:0]           op_weight,
   input  logic [255:0]           op_act,
   output logic [255:0]           mul_a,
   output logic [255:0]           mul_b,
   output logic                   stage_1_en,
   output logic                   stage_2_en,
   output logic                   stage_3_en,
   output logic                   stage_4_en,
   output logic                   dp_clear,
   input  logic [31:0]            dp_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_data
);
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
   state_t                 state;
   logic [MAX_BEATS_W-1:0] nb, cnt, cnt_nx;
   logic [3:0]             v, t;
   logic                   cap, hs;
   logic [31:0]            res;
   assign hs     = op_valid & op_ready;
   assign cnt_nx = cnt + MAX_BEATS_W'(1);
   assign {stage_4_en, stage_3_en, stage_2_en, stage_1_en} = v;
`ifdef ACC_RELU_EN
   assign res = dp_result[31] ? 32'h0 : dp_result;
`else
   assign res = dp_result;
`endif
   // v is the valid-token chain; t carries the last-beat tag alongside it
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         nb        <= '0;
         cnt       <= '0;
         v         <= '0;
         t         <= '0;
         cap       <= 1'b0;
         busy      <= 1'b0;
         op_ready  <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         dp_clear  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         v        <= {v[2:0], hs};
         t        <= {t[2:0], hs && cnt_nx == nb};
         cap      <= v[3] & t[3];
         dp_clear <= 1'b0;
         case (state)
            IDLE: if (start) begin
               nb   <= num_beats;
               cnt  <= '0;
               busy <= 1'b1;
               if (num_beats == '0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  out_data  <= '0;
               end else begin
                  state    <= CLEAR;
                  dp_clear <= 1'b1;
               end
            end
            CLEAR: begin
               state    <= RUN;
               op_ready <= 1'b1;
            end
            RUN: if (hs) begin
               mul_a <= op_weight;
               mul_b <= op_act;
               cnt   <= cnt_nx;
               if (cnt_nx == nb) begin
                  op_ready <= 1'b0;
                  state    <= DRAIN;
               end
            end
            DRAIN: if (cap) begin
               out_data  <= res;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed bench with an integer-valued model of the 4-stage MAC datapath.
module tb_datapath_sequencer;
   logic         clk = 0, reset = 1, start = 0, op_valid = 0, out_ready = 0;
   logic [15:0]  num_beats = 0;
   logic [255:0] op_weight = 0, op_act = 0, mul_a, mul_b;
   logic         busy, op_ready, stage_1_en, stage_2_en, stage_3_en, stage_4_en, dp_clear, out_valid;
   logic [31:0]  dp_result, out_data;
   int           errors = 0, checks = 0;

   datapath_sequencer #(.MAX_BEATS_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .num_beats(num_beats), .busy(busy),
      .op_valid(op_valid), .op_ready(op_ready), .op_weight(op_weight), .op_act(op_act),
      .mul_a(mul_a), .mul_b(mul_b), .stage_1_en(stage_1_en), .stage_2_en(stage_2_en),
      .stage_3_en(stage_3_en), .stage_4_en(stage_4_en), .dp_clear(dp_clear),
      .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   // small-integer float helpers: test values are exact integers
   function automatic int fp2i(input logic [31:0] f);
      int e, mag;
      if (f[30:0] == 0) return 0;
      e   = int'(f[30:23]);
      mag = int'({1'b1, f[22:0]} >> (150 - e));
      return f[31] ? -mag : mag;
   endfunction

   function automatic logic [31:0] i2fp(input int x);
      int mag, p;
      logic [31:0] sh;
      logic [7:0]  e;
      if (x == 0) return 32'h0;
      mag = x < 0 ? -x : x;
      p = 0;
      for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
      sh = 32'(mag) << (23 - p);
      e  = 8'(127 + p);
      return {x < 0, e, sh[22:0]};
   endfunction

   function automatic int dot(input logic [255:0] a, input logic [255:0] b);
      int s = 0;
      for (int i = 0; i < 8; i++) s += fp2i(a[32*i +: 32]) * fp2i(b[32*i +: 32]);
      return s;
   endfunction

   // datapath model
   int s1 = 0, s2 = 0, s3 = 0, acc = 0;
   always @(posedge clk) begin
      if (stage_1_en) s1 <= dot(mul_a, mul_b);
      if (stage_2_en) s2 <= s1;
      if (stage_3_en) s3 <= s2;
      if (reset || dp_clear) acc <= 0;
      else if (stage_4_en) acc <= acc + s3;
   end
   assign dp_result = i2fp(acc);

   // event monitor
   logic mon_clr = 0, ov_d = 0;
   int   cyc = 0, last_hs = 0, ov_cyc = 0, n1 = 0, n2 = 0, n3 = 0, n4 = 0, nclr = 0, run4 = 0, max4 = 0, ovl = 0;
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      ov_d <= out_valid;
      if (op_valid && op_ready) last_hs <= cyc;
      if (out_valid && !ov_d) ov_cyc <= cyc;
      if (mon_clr) begin
         n1 <= 0; n2 <= 0; n3 <= 0; n4 <= 0; nclr <= 0; run4 <= 0; max4 <= 0; ovl <= 0;
      end else begin
         n1   <= n1 + int'(stage_1_en);
         n2   <= n2 + int'(stage_2_en);
         n3   <= n3 + int'(stage_3_en);
         n4   <= n4 + int'(stage_4_en);
         nclr <= nclr + int'(dp_clear);
         run4 <= stage_4_en ? run4 + 1 : 0;
         if (stage_4_en && run4 + 1 > max4) max4 <= run4 + 1;
         if (dp_clear && (stage_1_en | stage_2_en | stage_3_en | stage_4_en)) ovl <= ovl + 1;
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      @(negedge clk) mon_clr = 1;
      @(negedge clk) mon_clr = 0;
   endtask

   task automatic job(input string tag, input int nb, input logic [31:0] w, input logic [31:0] a,
                      input bit bub, input logic [31:0] exp);
      int sent = 0, g = 0;
      bit tog = 1;
      clr_mon();
      op_weight = {8{w}};
      op_act    = {8{a}};
      start     = 1;
      num_beats = 16'(nb);
      @(negedge clk) start = 0;
      while (sent < nb && g < 200) begin
         op_valid = bub ? tog : 1'b1;
         tog = !tog;
         if (op_valid && op_ready) sent++;
         @(negedge clk) g++;
      end
      op_valid = 0;
      chk({tag, "_beats"}, 256'(sent), 256'(nb));
      g = 0;
      while (!out_valid && g < 40) @(negedge clk) g++;
      chk({tag, "_out_valid"}, 256'(out_valid), 256'(1));
      chk({tag, "_out_data"}, 256'(out_data), 256'(exp));
      out_ready = 1;
      @(negedge clk) out_ready = 0;
      chk({tag, "_ov_low"}, 256'({out_valid, busy}), 256'(0));
      chk({tag, "_latency"}, 256'(ov_cyc - last_hs), 256'(6));
      chk({tag, "_en_counts"}, 256'({8'(n1), 8'(n2), 8'(n3), 8'(n4)}), 256'({4{8'(nb)}}));
      chk({tag, "_clear_once"}, 256'(nclr), 256'(1));
      chk({tag, "_s4_run"}, 256'(max4), 256'(bub ? 1 : nb));
      chk({tag, "_no_overlap"}, 256'(ovl), 256'(0));
   endtask

   initial begin
      int g;
      logic [31:0] d0;
      repeat (3) @(negedge clk);
      chk("rst_outs", {busy, op_ready, stage_1_en, stage_2_en, stage_3_en, stage_4_en, dp_clear, out_valid, out_data}, 0);
      chk("rst_mul", mul_a | mul_b, 0);
      reset = 0;
      @(negedge clk);
      chk("idle_busy", 256'(busy), 256'(0));
      job("one_beat", 1, 32'h3F800000, 32'h40000000, 0, 32'h41800000);
      chk("mul_a_fed", mul_a, {8{32'h3F800000}});
      chk("mul_b_fed", mul_b, {8{32'h40000000}});
      job("three_b2b", 3, 32'h3F800000, 32'h40000000, 0, 32'h42400000);
      job("three_bubbles", 3, 32'h3F800000, 32'h40000000, 1, 32'h42400000);
`ifdef ACC_RELU_EN
      job("neg_relu", 1, 32'hBF800000, 32'h3F800000, 0, 32'h00000000);
`else
      job("neg", 1, 32'hBF800000, 32'h3F800000, 0, 32'hC1000000);
`endif
      // zero-beat job goes straight to DONE
      clr_mon();
      start = 1;
      num_beats = 0;
      @(negedge clk) start = 0;
      chk("zero_done", 256'({out_valid, busy}), 256'(2'b11));
      chk("zero_data", 256'(out_data), 256'(0));
      g = 0;
      repeat (10) begin
         @(negedge clk);
         if (!out_valid || out_data !== 0) g++;
      end
      chk("zero_hold", 256'(g), 256'(0));
      chk("zero_no_en", 256'({8'(n1), 8'(n2), 8'(n3), 8'(n4), 8'(nclr)}), 256'(0));
      out_ready = 1;
      @(negedge clk) out_ready = 0;
      chk("zero_release", 256'(out_valid), 256'(0));
      // reset while draining
      start = 1;
      num_beats = 1;
      op_weight = {8{32'h3F800000}};
      op_act = {8{32'h40000000}};
      @(negedge clk) start = 0;
      op_valid = 1;
      g = 0;
      while (!op_ready && g < 10) @(negedge clk) g++;
      @(negedge clk) op_valid = 0;
      chk("drain_state", 256'({busy, op_ready, stage_1_en}), 256'(3'b101));
      reset = 1;
      @(negedge clk);
      chk("drain_rst_outs", {busy, op_ready, stage_1_en, stage_2_en, stage_3_en, stage_4_en, dp_clear, out_valid, out_data}, 0);
      chk("drain_rst_mul", mul_a | mul_b, 0);
      reset = 0;
      d0 = 0;
      repeat (10) @(negedge clk) d0 |= {31'b0, out_valid};
      chk("drain_abandoned", 256'(d0), 256'(0));
      job("after_rst", 1, 32'h3F800000, 32'h40000000, 0, 32'h41800000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
